// File: rtl/seq_detect_moore_if.sv
// seq_detect_moore_if: serial stream, control and status bundle of the pattern detector
interface seq_detect_moore_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W = 8
);
  localparam int SW = $clog2(PAT_LEN + 1);
  logic din;
  logic din_valid;
  logic clear;
  logic dout;
  logic [CNT_W-1:0] match_count;
  logic [SW-1:0] state_o;
  modport master (output din, din_valid, clear, input dout, match_count, state_o);
  modport slave (input din, din_valid, clear, output dout, match_count, state_o);
endinterface

// File: rtl/seq_detect_moore.sv
// seq_detect_moore: Moore detector for a parametrised serial pattern with prefix fallback and saturating match count
module seq_detect_moore #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  seq_detect_moore_if.slave bus
);
  localparam int SW = $clog2(PAT_LEN + 1);
  localparam logic [SW-1:0] FULL = SW'(PAT_LEN);
  localparam logic [CNT_W-1:0] CMAX = '1;
  if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
    $error("PAT_LEN out of range 2..32");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
    $error("CNT_W out of range 1..32");
  end
  logic [SW-1:0] m, len, lim, nk, nlen;
  logic [PAT_LEN-1:0] hist, nhist;
  logic restart;
  // nk is the longest suffix of the new history that is a pattern prefix, bounded by lim
  always_comb begin
    restart = (m == FULL) && !OVERLAP;
    nhist = restart ? PAT_LEN'(bus.din) : {hist[PAT_LEN-2:0], bus.din};
    nlen = restart ? SW'(1) : (len == FULL ? FULL : len + 1'b1);
    lim = restart ? SW'(1) : (m == FULL ? FULL : m + 1'b1);
    lim = lim > nlen ? nlen : lim;
    nk = '0;
    for (int k = 1; k <= PAT_LEN; k++)
      if (SW'(k) <= lim && ((nhist ^ (PATTERN >> (PAT_LEN - k))) & ({PAT_LEN{1'b1}} >> (PAT_LEN - k))) == '0)
        nk = SW'(k);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      m <= '0;
      len <= '0;
      hist <= '0;
      bus.dout <= 1'b0;
      bus.match_count <= '0;
    end else if (bus.clear) begin
      m <= '0;
      len <= '0;
      hist <= '0;
      bus.dout <= 1'b0;
      bus.match_count <= '0;
    end else if (bus.din_valid) begin
      m <= nk;
      len <= nlen;
      hist <= nhist;
      bus.dout <= nk == FULL;
      if (nk == FULL && bus.match_count != CMAX) bus.match_count <= bus.match_count + 1'b1;
    end
  assign bus.state_o = m;
endmodule

// File: tb/tb_seq_detect_moore.sv
// tb_seq_detect_moore: randomized and directed checks of several detector configurations against a queue-based model
module tb_seq_detect_moore;
  localparam int NI = 6;
  localparam int NS[NI] = '{4, 4, 4, 4, 4, 6};
  localparam logic [31:0] PS[NI] = '{32'hB, 32'hB, 32'hF, 32'hF, 32'hB, 32'h36};
  localparam bit OV[NI] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam int CW[NI] = '{8, 8, 8, 8, 2, 4};
  logic clk = 1'b0, reset = 1'b0, din = 1'b0, din_valid = 1'b0, clear = 1'b0;
  logic dq[NI];
  logic [31:0] st[NI], cnt[NI];
  int n_cmp = 0, n_err = 0;
  int mm[NI], mc[NI];
  bit mq[NI][$];
  bit sa[7] = '{1, 0, 1, 1, 0, 1, 1};
  int ea[7] = '{1, 2, 3, 4, 2, 3, 4};
  bit sb[6] = '{1, 0, 1, 0, 1, 1};
  int eb[6] = '{1, 2, 3, 2, 3, 4};
  bit sc[5] = '{1, 1, 0, 1, 1};
  int ec[5] = '{1, 1, 2, 3, 4};
  bit sd[4] = '{1, 0, 1, 1};
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_u
    seq_detect_moore_if #(.PAT_LEN(NS[g]), .CNT_W(CW[g])) bus ();
    assign bus.din = din;
    assign bus.din_valid = din_valid;
    assign bus.clear = clear;
    seq_detect_moore #(
      .PAT_LEN(NS[g]), .PATTERN(PS[g][NS[g]-1:0]), .OVERLAP(OV[g]), .CNT_W(CW[g])
    ) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    assign dq[g] = bus.dout;
    assign st[g] = 32'(bus.state_o);
    assign cnt[g] = 32'(bus.match_count);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void model_reset();
    for (int g = 0; g < NI; g++) begin
      mm[g] = 0;
      mc[g] = 0;
      mq[g].delete();
    end
  endfunction
  // longest recent run of received bits that reads as the start of the pattern
  function automatic void model_step(input bit b);
    for (int g = 0; g < NI; g++) begin
      int n, eff, lim, k;
      logic [31:0] p;
      bit ok;
      n = NS[g];
      p = PS[g];
      if (mm[g] == n && !OV[g]) mq[g].delete();
      eff = (mm[g] == n) ? (OV[g] ? n : 0) : mm[g];
      mq[g].push_back(b);
      if (mq[g].size() > n) void'(mq[g].pop_front());
      lim = eff + 1;
      if (lim > n) lim = n;
      if (lim > mq[g].size()) lim = mq[g].size();
      k = 0;
      for (int kk = 1; kk <= lim; kk++) begin
        ok = 1'b1;
        for (int i = 0; i < kk; i++)
          if (mq[g][mq[g].size() - kk + i] != p[n - 1 - i]) ok = 1'b0;
        if (ok) k = kk;
      end
      mm[g] = k;
      if (k == n && mc[g] < (1 << CW[g]) - 1) mc[g]++;
    end
  endfunction
  task automatic cyc(input bit d, input bit v, input bit c);
    din = d;
    din_valid = v;
    clear = c;
    @(posedge clk);
    if (c) model_reset();
    else if (v) model_step(d);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("u%0d_dout", g), 32'(dq[g]), 32'(mm[g] == NS[g]));
      chk($sformatf("u%0d_state", g), st[g], mm[g]);
      chk($sformatf("u%0d_count", g), cnt[g], mc[g]);
    end
  endtask
  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    model_reset();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("u%0d_rst_dout", g), 32'(dq[g]), 0);
      chk($sformatf("u%0d_rst_state", g), st[g], 0);
      chk($sformatf("u%0d_rst_count", g), cnt[g], 0);
    end
    reset = 1'b1;
  endtask
  initial begin
    model_reset();
    #12;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("u%0d_init_dout", g), 32'(dq[g]), 0);
      chk($sformatf("u%0d_init_state", g), st[g], 0);
      chk($sformatf("u%0d_init_count", g), cnt[g], 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(sa[i], 1'b1, 1'b0);
      chk("ov_state", st[0], ea[i]);
      chk("ov_dout", 32'(dq[0]), 32'(ea[i] == 4));
    end
    chk("ov_count", cnt[0], 2);
    chk("nov_state", st[1], 1);
    chk("nov_count", cnt[1], 1);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(sb[i], 1'b1, 1'b0);
      chk("fallback_a", st[0], eb[i]);
    end
    chk("fallback_a_count", cnt[0], 1);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(sc[i], 1'b1, 1'b0);
      chk("fallback_b", st[0], ec[i]);
    end
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      chk("ones_ov_dout", 32'(dq[2]), 32'(i >= 4));
      chk("ones_nov_dout", 32'(dq[3]), 32'(i == 4 || i == 8));
      if (i == 6) chk("ones_ov_count", cnt[2], 3);
    end
    chk("ones_nov_count", cnt[3], 2);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(i[0], 1'b0, 1'b0);
      chk("gap_state", st[0], 1);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("gap_match", 32'(dq[0]), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(~i[0], 1'b0, 1'b0);
      chk("hold_dout", 32'(dq[0]), 1);
    end
    cyc(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 4; i++) cyc(sd[i], 1'b1, 1'b0);
    chk("five_count", cnt[0], 5);
    chk("sat_count", cnt[4], 3);
    cyc(1'b1, 1'b1, 1'b1);
    chk("clr_state", st[0], 0);
    chk("clr_dout", 32'(dq[0]), 0);
    chk("clr_count", cnt[0], 0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    pulse_reset();
    cyc(1'b1, 1'b1, 1'b0);
    chk("post_rst_state", st[0], 1);
    chk("post_rst_dout", 32'(dq[0]), 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_detect_moore.md
# seq_detect_moore

Parametrised Moore-style serial pattern detector, successor to the team's fixed 4-bit "1011" detector. It detects a compile-time pattern of length N in a 1-bit serial stream qualified by a valid strobe. It supports overlapping or non-overlapping matching and keeps a saturating match counter. It sits on the serial data path behind a deserialiser or line receiver and flags frame markers or sync words to downstream control logic.

## Interface
- PAT_LEN, 4: pattern length N; legal range 2..32.
- PATTERN, 4'b1011: pattern value, PAT_LEN bits; PATTERN[PAT_LEN-1] is the first bit received.
- OVERLAP, 1: 1 = a completed match may share bits with the next match; 0 = matching restarts from scratch after every match.
- CNT_W, 8: width of match_count; legal range 1..32.
- SW: derived, $clog2(PAT_LEN+1); width of state_o. Not user-set.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled only when high.
- clear  in  1  synchronous clear of the FSM and the counter.
- dout  out  1  Moore match flag; high while the FSM is in state MATCH.
- match_count  out  CNT_W  number of completed matches, saturating.
- state_o  out  SW  current matched-prefix length m (0..N), for debug and coverage.

## Operation
- States: S0..S(N-1) mean m bits of the pattern are matched. MATCH is encoded as m = N.
- dout = (m == N). It is decoded only from the state register, never from din or din_valid.
- Sampling: the FSM advances only on an edge where din_valid = 1. When din_valid = 0, all state holds, including dout. dout therefore stays high across valid gaps until the next valid bit.
- History register: holds the last N valid bits since the last restart, along with a valid-length count.
- Next state on a valid bit: the largest k in 0..min(eff+1, N) such that the last k received bits equal PATTERN[N-1 -: k].
  - eff = m in normal states.
  - In MATCH with OVERLAP=1, eff = N, but k is capped at N. Consecutive matches are possible only for self-overlapping patterns.
  - In MATCH with OVERLAP=0, eff = 0. History is discarded, and only the new bit is compared against PATTERN[N-1].
- Fallback is a full prefix/suffix (KMP-equivalent) search over the history. Dropping straight to S0 on a mismatch is not acceptable.
- Counter: match_count increments by 1 on every edge whose next state is MATCH, including MATCH→MATCH. It saturates at 2^CNT_W-1 and never wraps.
- clear: on an edge with clear = 1:
  - m goes to 0, the history is emptied, and match_count goes to 0.
  - clear has priority over din_valid; the bit presented in that cycle is discarded.
- reset low: immediately sets m = 0, dout = 0, match_count = 0, state_o = 0, and empties the history. This applies mid-pattern too; a partial match is lost.
- Reset values: dout 0, match_count 0, state_o 0.

## Timing
- Latency: dout rises in the cycle after the edge that samples the final pattern bit. That is 1 clk after the last valid bit is presented.
- dout and match_count change on the same edge. match_count reflects the new match in the same cycle dout rises.
- No combinational path from din, din_valid, or clear to any output.
- Reset deassertion is synchronised externally. The first valid bit may be sampled on the first edge after release.

## Test plan
- Default params, OVERLAP=1, valid bits 1,0,1,1,0,1,1 → dout high after bits 4 and 7 (one cycle each), match_count = 2, state_o sequence 1,2,3,4,2,3,4.
- Default params, OVERLAP=0, same stream → single match after bit 4, final state_o = 1, match_count = 1.
- Fallback: 1,0,1,0,1,1 → state_o 1,2,3,2,3,4, one match. Also check 1,1,0,1,1 → state_o 1,1,2,3,4.
- PATTERN=4'b1111: OVERLAP=1 with 6 ones → dout high 3 consecutive cycles, count = 3. OVERLAP=0 with 8 ones → matches after bits 4 and 8 only, count = 2.
- Valid gaps and holds: 1, (din_valid=0 for 3 cycles with din toggling), 0,1,1 → match, with state_o frozen during gaps. After the match, hold din_valid=0 for 5 cycles → dout stays 1 throughout.
- Boundaries:
  - CNT_W=2 with 5 matches → match_count stuck at 3.
  - clear with din_valid=1 in MATCH → next cycle state_o = 0, dout = 0, count = 0, bit ignored.
  - reset pulsed after 1,0,1 → outputs 0 immediately. A following 1 gives state_o = 1, no match.
